// File: rtl/axi4_channel_buffer_pkg.sv
// axi4_channel_buffer_pkg: AXI4 field widths, bus-width helpers and the
// bsg_axi4 bus / per-channel payload struct declaration macros.
`ifndef AXI4_CHANNEL_BUFFER_PKG_SV
`define AXI4_CHANNEL_BUFFER_PKG_SV

package axi4_channel_buffer_pkg;

  localparam int axi4_len_w    = 8;
  localparam int axi4_size_w   = 3;
  localparam int axi4_burst_w  = 2;
  localparam int axi4_cache_w  = 4;
  localparam int axi4_prot_w   = 3;
  localparam int axi4_qos_w    = 4;
  localparam int axi4_region_w = 4;
  localparam int axi4_resp_w   = 2;

  // len+size+burst+lock+cache+prot+qos+region
  localparam int axi4_ax_ctrl_w =
    axi4_len_w + axi4_size_w + axi4_burst_w + 1 +
    axi4_cache_w + axi4_prot_w + axi4_qos_w + axi4_region_w;

  function automatic int mosi_w_f(int idw, int aw, int dw);
    return 2 * (idw + aw + axi4_ax_ctrl_w + 1)
         + dw + dw / 8 + 4;
  endfunction

  function automatic int miso_w_f(int idw, int dw);
    return 2 * idw + dw + 2 * axi4_resp_w + 6;
  endfunction

endpackage

`define BSG_AXI4_MOSI_BUS_WIDTH(sn_m, idw_m, aw_m, dw_m) \
  ((sn_m) * axi4_channel_buffer_pkg::mosi_w_f(idw_m, aw_m, dw_m))

`define BSG_AXI4_MISO_BUS_WIDTH(sn_m, idw_m, aw_m, dw_m) \
  ((sn_m) * axi4_channel_buffer_pkg::miso_w_f(idw_m, dw_m))

`define DECLARE_BSG_AXI4_BUS_S(sn_m, idw_m, aw_m, dw_m, mosi_m, miso_m) \
  typedef struct packed { \
    logic [idw_m-1:0]         awid; \
    logic [aw_m-1:0]          awaddr; \
    logic [axi4_len_w-1:0]    awlen; \
    logic [axi4_size_w-1:0]   awsize; \
    logic [axi4_burst_w-1:0]  awburst; \
    logic                     awlock; \
    logic [axi4_cache_w-1:0]  awcache; \
    logic [axi4_prot_w-1:0]   awprot; \
    logic [axi4_qos_w-1:0]    awqos; \
    logic [axi4_region_w-1:0] awregion; \
    logic                     awvalid; \
    logic [dw_m-1:0]          wdata; \
    logic [dw_m/8-1:0]        wstrb; \
    logic                     wlast; \
    logic                     wvalid; \
    logic                     bready; \
    logic [idw_m-1:0]         arid; \
    logic [aw_m-1:0]          araddr; \
    logic [axi4_len_w-1:0]    arlen; \
    logic [axi4_size_w-1:0]   arsize; \
    logic [axi4_burst_w-1:0]  arburst; \
    logic                     arlock; \
    logic [axi4_cache_w-1:0]  arcache; \
    logic [axi4_prot_w-1:0]   arprot; \
    logic [axi4_qos_w-1:0]    arqos; \
    logic [axi4_region_w-1:0] arregion; \
    logic                     arvalid; \
    logic                     rready; \
  } mosi_m; \
  typedef struct packed { \
    logic                     awready; \
    logic                     wready; \
    logic [idw_m-1:0]         bid; \
    logic [axi4_resp_w-1:0]   bresp; \
    logic                     bvalid; \
    logic                     arready; \
    logic [idw_m-1:0]         rid; \
    logic [dw_m-1:0]          rdata; \
    logic [axi4_resp_w-1:0]   rresp; \
    logic                     rlast; \
    logic                     rvalid; \
  } miso_m;

`define DECLARE_AXI4_BUF_PAYLOAD_S(idw_m, aw_m, dw_m) \
  typedef struct packed { \
    logic [idw_m-1:0]         id; \
    logic [aw_m-1:0]          addr; \
    logic [axi4_len_w-1:0]    len; \
    logic [axi4_size_w-1:0]   size; \
    logic [axi4_burst_w-1:0]  burst; \
    logic                     lock; \
    logic [axi4_cache_w-1:0]  cache; \
    logic [axi4_prot_w-1:0]   prot; \
    logic [axi4_qos_w-1:0]    qos; \
    logic [axi4_region_w-1:0] region; \
  } aw_payload_s; \
  typedef aw_payload_s ar_payload_s; \
  typedef struct packed { \
    logic [dw_m-1:0]          data; \
    logic [dw_m/8-1:0]        strb; \
    logic                     last; \
  } w_payload_s; \
  typedef struct packed { \
    logic [idw_m-1:0]         id; \
    logic [axi4_resp_w-1:0]   resp; \
  } b_payload_s; \
  typedef struct packed { \
    logic [idw_m-1:0]         id; \
    logic [dw_m-1:0]          data; \
    logic [axi4_resp_w-1:0]   resp; \
    logic                     last; \
  } r_payload_s;

`endif

// File: rtl/axi4_buf_fifo.sv
// axi4_buf_fifo: registered valid/ready FIFO, flop-array storage, 1-cycle latency.
// Ports: i_clk, i_rst_n (async low); i_valid/o_ready/i_data in; o_valid/i_ready/o_data out.
module axi4_buf_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [width_p-1:0] i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [width_p-1:0] o_data
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  r_mem [els_p];
  logic [ptr_w_lp-1:0] r_wptr;
  logic [ptr_w_lp-1:0] r_rptr;
  logic [cnt_w_lp-1:0] r_cnt;
  logic                r_live;
  logic                w_enq;
  logic                w_deq;

  // r_live keeps ready low until the first edge out of reset
  assign o_ready = r_live & (r_cnt != cnt_w_lp'(els_p));
  assign o_valid = (r_cnt != '0);
  assign o_data  = r_mem[r_rptr];
  assign w_enq   = i_valid & o_ready;
  assign w_deq   = o_valid & i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_live <= 1'b0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_enq) r_wptr <= r_wptr + ptr_w_lp'(1);
      if (w_deq) r_rptr <= r_rptr + ptr_w_lp'(1);
      unique case (1'b1)
        (w_enq & ~w_deq): r_cnt <= r_cnt + cnt_w_lp'(1);
        (~w_enq & w_deq): r_cnt <= r_cnt - cnt_w_lp'(1);
        default:          r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_enq) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/axi4_channel_buffer.sv
// axi4_channel_buffer: per-channel FIFO buffering of an AXI4 link (AW/W/AR fwd, B/R rev).
// Ports: clk_i, reset_n_i, s_axi4_i/o, m_axi4_o/i, idle_o. Option: AXI4_BUF_OUTSTANDING_LIMIT_EN.
module axi4_channel_buffer
  import axi4_channel_buffer_pkg::*;
#(
  parameter int id_width_p        = 4,
  parameter int addr_width_p      = 32,
  parameter int data_width_p      = 32,
  parameter int aw_depth_p        = 2,
  parameter int w_depth_p         = 4,
  parameter int b_depth_p         = 2,
  parameter int ar_depth_p        = 2,
  parameter int r_depth_p         = 4,
  parameter int max_outstanding_p = 8,
  localparam int mosi_w_lp = `BSG_AXI4_MOSI_BUS_WIDTH(1, id_width_p, addr_width_p, data_width_p),
  localparam int miso_w_lp = `BSG_AXI4_MISO_BUS_WIDTH(1, id_width_p, addr_width_p, data_width_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [mosi_w_lp-1:0] s_axi4_i,
  output logic [miso_w_lp-1:0] s_axi4_o,
  output logic [mosi_w_lp-1:0] m_axi4_o,
  input  logic [miso_w_lp-1:0] m_axi4_i,
  output logic                 idle_o
);

  `DECLARE_BSG_AXI4_BUS_S(1, id_width_p, addr_width_p, data_width_p, mosi_s, miso_s)
  `DECLARE_AXI4_BUF_PAYLOAD_S(id_width_p, addr_width_p, data_width_p)

  mosi_s w_s_req;
  miso_s w_s_rsp;
  mosi_s w_m_req;
  miso_s w_m_rsp;

  assign w_s_req  = s_axi4_i;
  assign w_m_rsp  = m_axi4_i;
  assign s_axi4_o = w_s_rsp;
  assign m_axi4_o = w_m_req;

  aw_payload_s w_aw_in, w_aw_out;
  w_payload_s  w_w_in,  w_w_out;
  b_payload_s  w_b_in,  w_b_out;
  ar_payload_s w_ar_in, w_ar_out;
  r_payload_s  w_r_in,  w_r_out;

  logic w_aw_rdy, w_aw_vld;
  logic w_w_rdy,  w_w_vld;
  logic w_b_rdy,  w_b_vld;
  logic w_ar_rdy, w_ar_vld;
  logic w_r_rdy,  w_r_vld;
  logic w_ar_hold, w_aw_hold;
  logic w_cnt_idle;

  assign w_aw_in = '{
    id: w_s_req.awid, addr: w_s_req.awaddr,
    len: w_s_req.awlen, size: w_s_req.awsize,
    burst: w_s_req.awburst, lock: w_s_req.awlock,
    cache: w_s_req.awcache, prot: w_s_req.awprot,
    qos: w_s_req.awqos, region: w_s_req.awregion};

  assign w_ar_in = '{
    id: w_s_req.arid, addr: w_s_req.araddr,
    len: w_s_req.arlen, size: w_s_req.arsize,
    burst: w_s_req.arburst, lock: w_s_req.arlock,
    cache: w_s_req.arcache, prot: w_s_req.arprot,
    qos: w_s_req.arqos, region: w_s_req.arregion};

  assign w_w_in = '{
    data: w_s_req.wdata, strb: w_s_req.wstrb,
    last: w_s_req.wlast};

  assign w_b_in = '{id: w_m_rsp.bid, resp: w_m_rsp.bresp};

  assign w_r_in = '{
    id: w_m_rsp.rid, data: w_m_rsp.rdata,
    resp: w_m_rsp.rresp, last: w_m_rsp.rlast};

  axi4_buf_fifo #(.width_p($bits(aw_payload_s)), .els_p(aw_depth_p)) u_aw (
    .i_clk(clk_i), .i_rst_n(reset_n_i),
    .i_valid(w_s_req.awvalid), .o_ready(w_aw_rdy), .i_data(w_aw_in),
    .o_valid(w_aw_vld), .i_ready(w_m_rsp.awready & ~w_aw_hold),
    .o_data(w_aw_out));

  axi4_buf_fifo #(.width_p($bits(w_payload_s)), .els_p(w_depth_p)) u_w (
    .i_clk(clk_i), .i_rst_n(reset_n_i),
    .i_valid(w_s_req.wvalid), .o_ready(w_w_rdy), .i_data(w_w_in),
    .o_valid(w_w_vld), .i_ready(w_m_rsp.wready),
    .o_data(w_w_out));

  axi4_buf_fifo #(.width_p($bits(b_payload_s)), .els_p(b_depth_p)) u_b (
    .i_clk(clk_i), .i_rst_n(reset_n_i),
    .i_valid(w_m_rsp.bvalid), .o_ready(w_b_rdy), .i_data(w_b_in),
    .o_valid(w_b_vld), .i_ready(w_s_req.bready),
    .o_data(w_b_out));

  axi4_buf_fifo #(.width_p($bits(ar_payload_s)), .els_p(ar_depth_p)) u_ar (
    .i_clk(clk_i), .i_rst_n(reset_n_i),
    .i_valid(w_s_req.arvalid), .o_ready(w_ar_rdy), .i_data(w_ar_in),
    .o_valid(w_ar_vld), .i_ready(w_m_rsp.arready & ~w_ar_hold),
    .o_data(w_ar_out));

  axi4_buf_fifo #(.width_p($bits(r_payload_s)), .els_p(r_depth_p)) u_r (
    .i_clk(clk_i), .i_rst_n(reset_n_i),
    .i_valid(w_m_rsp.rvalid), .o_ready(w_r_rdy), .i_data(w_r_in),
    .o_valid(w_r_vld), .i_ready(w_s_req.rready),
    .o_data(w_r_out));

`ifdef AXI4_BUF_OUTSTANDING_LIMIT_EN
  localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);

  logic [cnt_w_lp-1:0] r_rd_cnt;
  logic [cnt_w_lp-1:0] r_wr_cnt;
  logic w_rd_inc, w_rd_dec, w_wr_inc, w_wr_dec;

  // a held head keeps valid low, so valid never drops without a handshake
  assign w_ar_hold = (r_rd_cnt == cnt_w_lp'(max_outstanding_p));
  assign w_aw_hold = (r_wr_cnt == cnt_w_lp'(max_outstanding_p));
  assign w_rd_inc  = w_ar_vld & ~w_ar_hold & w_m_rsp.arready;
  assign w_rd_dec  = w_m_rsp.rvalid & w_r_rdy & w_m_rsp.rlast;
  assign w_wr_inc  = w_aw_vld & ~w_aw_hold & w_m_rsp.awready;
  assign w_wr_dec  = w_m_rsp.bvalid & w_b_rdy;
  assign w_cnt_idle = (r_rd_cnt == '0) & (r_wr_cnt == '0);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      assert (!(w_rd_dec && !w_rd_inc && r_rd_cnt == '0))
        else $error("rd_cnt underflow");
      assert (!(w_wr_dec && !w_wr_inc && r_wr_cnt == '0))
        else $error("wr_cnt underflow");
      assert (!(w_rd_inc && !w_rd_dec && w_ar_hold))
        else $error("rd_cnt overflow");
      assert (!(w_wr_inc && !w_wr_dec && w_aw_hold))
        else $error("wr_cnt overflow");
      unique case (1'b1)
        (w_rd_inc & ~w_rd_dec): r_rd_cnt <= r_rd_cnt + cnt_w_lp'(1);
        (~w_rd_inc & w_rd_dec): r_rd_cnt <= r_rd_cnt - cnt_w_lp'(1);
        default:                r_rd_cnt <= r_rd_cnt;
      endcase
      unique case (1'b1)
        (w_wr_inc & ~w_wr_dec): r_wr_cnt <= r_wr_cnt + cnt_w_lp'(1);
        (~w_wr_inc & w_wr_dec): r_wr_cnt <= r_wr_cnt - cnt_w_lp'(1);
        default:                r_wr_cnt <= r_wr_cnt;
      endcase
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (max_outstanding_p == 0);
  assign w_ar_hold    = 1'b0;
  assign w_aw_hold    = 1'b0;
  assign w_cnt_idle   = 1'b1;
`endif

  always_comb begin
    w_m_req          = '0;
    w_m_req.awid     = w_aw_out.id;
    w_m_req.awaddr   = w_aw_out.addr;
    w_m_req.awlen    = w_aw_out.len;
    w_m_req.awsize   = w_aw_out.size;
    w_m_req.awburst  = w_aw_out.burst;
    w_m_req.awlock   = w_aw_out.lock;
    w_m_req.awcache  = w_aw_out.cache;
    w_m_req.awprot   = w_aw_out.prot;
    w_m_req.awqos    = w_aw_out.qos;
    w_m_req.awregion = w_aw_out.region;
    w_m_req.awvalid  = w_aw_vld & ~w_aw_hold;
    w_m_req.wdata    = w_w_out.data;
    w_m_req.wstrb    = w_w_out.strb;
    w_m_req.wlast    = w_w_out.last;
    w_m_req.wvalid   = w_w_vld;
    w_m_req.bready   = w_b_rdy;
    w_m_req.arid     = w_ar_out.id;
    w_m_req.araddr   = w_ar_out.addr;
    w_m_req.arlen    = w_ar_out.len;
    w_m_req.arsize   = w_ar_out.size;
    w_m_req.arburst  = w_ar_out.burst;
    w_m_req.arlock   = w_ar_out.lock;
    w_m_req.arcache  = w_ar_out.cache;
    w_m_req.arprot   = w_ar_out.prot;
    w_m_req.arqos    = w_ar_out.qos;
    w_m_req.arregion = w_ar_out.region;
    w_m_req.arvalid  = w_ar_vld & ~w_ar_hold;
    w_m_req.rready   = w_r_rdy;
  end

  always_comb begin
    w_s_rsp         = '0;
    w_s_rsp.awready = w_aw_rdy;
    w_s_rsp.wready  = w_w_rdy;
    w_s_rsp.bid     = w_b_out.id;
    w_s_rsp.bresp   = w_b_out.resp;
    w_s_rsp.bvalid  = w_b_vld;
    w_s_rsp.arready = w_ar_rdy;
    w_s_rsp.rid     = w_r_out.id;
    w_s_rsp.rdata   = w_r_out.data;
    w_s_rsp.rresp   = w_r_out.resp;
    w_s_rsp.rlast   = w_r_out.last;
    w_s_rsp.rvalid  = w_r_vld;
  end

  assign idle_o = ~w_aw_vld & ~w_w_vld & ~w_b_vld
                & ~w_ar_vld & ~w_r_vld & w_cnt_idle;

endmodule

// File: tb/tb_axi4_channel_buffer.sv
// tb_axi4_channel_buffer: directed + random stimulus against a queue model
// of five bounded FIFOs; option AXI4_BUF_OUTSTANDING_LIMIT_EN adds a cap test.
module tb_axi4_channel_buffer;
  import axi4_channel_buffer_pkg::*;

  localparam int IDW  = 4;
  localparam int ADW  = 32;
  localparam int DW   = 32;
  localparam int MAXO = 2;
  localparam int AWD  = 2;
  localparam int WD   = 4;
  localparam int BD   = 2;
  localparam int ARD  = 2;
  localparam int RD   = 4;

  `DECLARE_BSG_AXI4_BUS_S(1, IDW, ADW, DW, mosi_s, miso_s)

  typedef logic [255:0] vec_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  mosi_s s_req, m_req;
  miso_s s_rsp, m_rsp;
  logic  idle;

  axi4_channel_buffer #(
    .id_width_p(IDW), .addr_width_p(ADW), .data_width_p(DW),
    .aw_depth_p(AWD), .w_depth_p(WD), .b_depth_p(BD),
    .ar_depth_p(ARD), .r_depth_p(RD), .max_outstanding_p(MAXO)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .s_axi4_i(s_req), .s_axi4_o(s_rsp),
    .m_axi4_o(m_req), .m_axi4_i(m_rsp),
    .idle_o(idle));

  always #5 clk = ~clk;

  vec_t awq[$], wq[$], bq[$], arq[$], rq[$];
  bit   live;
  int   rd, wr;
  int   n_vec, n_bad;
  bit   g_w_enq, g_ar_enq;

  function automatic vec_t aw_of(mosi_s x);
    return 256'({x.awid, x.awaddr, x.awlen, x.awsize, x.awburst,
      x.awlock, x.awcache, x.awprot, x.awqos, x.awregion});
  endfunction

  function automatic vec_t ar_of(mosi_s x);
    return 256'({x.arid, x.araddr, x.arlen, x.arsize, x.arburst,
      x.arlock, x.arcache, x.arprot, x.arqos, x.arregion});
  endfunction

  function automatic vec_t w_of(mosi_s x);
    return 256'({x.wdata, x.wstrb, x.wlast});
  endfunction

  function automatic vec_t b_of(miso_s x);
    return 256'({x.bid, x.bresp});
  endfunction

  function automatic vec_t r_of(miso_s x);
    return 256'({x.rid, x.rdata, x.rresp, x.rlast});
  endfunction

  function automatic bit ar_lim();
`ifdef AXI4_BUF_OUTSTANDING_LIMIT_EN
    return rd >= MAXO;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit aw_lim();
`ifdef AXI4_BUF_OUTSTANDING_LIMIT_EN
    return wr >= MAXO;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit idle_exp();
    bit e;
    e = awq.size() == 0 && wq.size() == 0 && bq.size() == 0
      && arq.size() == 0 && rq.size() == 0;
`ifdef AXI4_BUF_OUTSTANDING_LIMIT_EN
    e = e && rd == 0 && wr == 0;
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input vec_t obs, input vec_t exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk1("s_awready", s_rsp.awready, live && awq.size() < AWD);
    chk1("m_awvalid", m_req.awvalid, awq.size() > 0 && !aw_lim());
    if (awq.size() > 0) chk("m_aw", aw_of(m_req), awq[0]);
    chk1("s_wready", s_rsp.wready, live && wq.size() < WD);
    chk1("m_wvalid", m_req.wvalid, wq.size() > 0);
    if (wq.size() > 0) chk("m_w", w_of(m_req), wq[0]);
    chk1("m_bready", m_req.bready, live && bq.size() < BD);
    chk1("s_bvalid", s_rsp.bvalid, bq.size() > 0);
    if (bq.size() > 0) chk("s_b", b_of(s_rsp), bq[0]);
    chk1("s_arready", s_rsp.arready, live && arq.size() < ARD);
    chk1("m_arvalid", m_req.arvalid, arq.size() > 0 && !ar_lim());
    if (arq.size() > 0) chk("m_ar", ar_of(m_req), arq[0]);
    chk1("m_rready", m_req.rready, live && rq.size() < RD);
    chk1("s_rvalid", s_rsp.rvalid, rq.size() > 0);
    if (rq.size() > 0) chk("s_r", r_of(s_rsp), rq[0]);
    chk1("idle", idle, idle_exp());
  endtask

  // check outputs, work out this cycle's handshakes, clock once, update model
  task automatic step();
    bit   aw_e, aw_d, w_e, w_d, b_e, b_d, ar_e, ar_d, r_e, r_d, r_l;
    vec_t aw_v, w_v, b_v, ar_v, r_v;
    check_all();
    aw_e = s_req.awvalid && live && awq.size() < AWD;
    aw_d = awq.size() > 0 && !aw_lim() && m_rsp.awready;
    w_e  = s_req.wvalid && live && wq.size() < WD;
    w_d  = wq.size() > 0 && m_rsp.wready;
    b_e  = m_rsp.bvalid && live && bq.size() < BD;
    b_d  = bq.size() > 0 && s_req.bready;
    ar_e = s_req.arvalid && live && arq.size() < ARD;
    ar_d = arq.size() > 0 && !ar_lim() && m_rsp.arready;
    r_e  = m_rsp.rvalid && live && rq.size() < RD;
    r_d  = rq.size() > 0 && s_req.rready;
    r_l  = m_rsp.rlast;
    aw_v = aw_of(s_req);
    w_v  = w_of(s_req);
    b_v  = b_of(m_rsp);
    ar_v = ar_of(s_req);
    r_v  = r_of(m_rsp);
    @(posedge clk);
    #1;
    if (aw_d) void'(awq.pop_front());
    if (w_d)  void'(wq.pop_front());
    if (b_d)  void'(bq.pop_front());
    if (ar_d) void'(arq.pop_front());
    if (r_d)  void'(rq.pop_front());
    if (aw_e) awq.push_back(aw_v);
    if (w_e)  wq.push_back(w_v);
    if (b_e)  bq.push_back(b_v);
    if (ar_e) arq.push_back(ar_v);
    if (r_e)  rq.push_back(r_v);
    rd = rd + int'(ar_d) - int'(r_e && r_l);
    wr = wr + int'(aw_d) - int'(b_e);
    live = 1'b1;
    g_w_enq  = w_e;
    g_ar_enq = ar_e;
  endtask

  task automatic idle_inputs();
    s_req = '0;
    m_rsp = '0;
  endtask

  task automatic rand_drive();
    logic [511:0] rv;
    for (int i = 0; i < 16; i++) rv[i*32 +: 32] = $urandom;
    s_req = rv[$bits(mosi_s)-1:0];
    for (int i = 0; i < 16; i++) rv[i*32 +: 32] = $urandom;
    m_rsp = rv[$bits(miso_s)-1:0];
`ifdef AXI4_BUF_OUTSTANDING_LIMIT_EN
    m_rsp.rlast  = 1'b0;
    m_rsp.bvalid = 1'b0;
`endif
  endtask

  task automatic model_reset();
    awq.delete(); wq.delete(); bq.delete();
    arq.delete(); rq.delete();
    live = 1'b0;
    rd = 0;
    wr = 0;
  endtask

  initial begin
    logic [31:0] wd [8];
    logic [3:0]  ws [8];
    int          bi;
    n_vec = 0;
    n_bad = 0;
    model_reset();
    idle_inputs();

    // reset state
    #3;
    chk1("rst_s_awready", s_rsp.awready, 1'b0);
    chk1("rst_s_wready", s_rsp.wready, 1'b0);
    chk1("rst_s_arready", s_rsp.arready, 1'b0);
    chk1("rst_m_bready", m_req.bready, 1'b0);
    chk1("rst_m_rready", m_req.rready, 1'b0);
    chk1("rst_idle", idle, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk1("rst_rel_wready", s_rsp.wready, 1'b0);
    @(posedge clk);
    #1;
    live = 1'b1;
    chk1("rdy_after_edge", s_rsp.awready & s_rsp.wready & s_rsp.arready, 1'b1);
    step();

    // single AR then single R
    idle_inputs();
    s_req.arvalid = 1'b1;
    s_req.arid    = 4'd3;
    s_req.araddr  = 32'h1000;
    s_req.arlen   = 8'd0;
    m_rsp.arready = 1'b1;
    step();
    s_req.arvalid = 1'b0;
    chk1("t2_m_arvalid", m_req.arvalid, 1'b1);
    chk("t2_arid", 256'(m_req.arid), 256'(4'd3));
    chk("t2_araddr", 256'(m_req.araddr), 256'(32'h1000));
    step();
    m_rsp.rvalid = 1'b1;
    m_rsp.rid    = 4'd3;
    m_rsp.rdata  = $urandom;
    m_rsp.rlast  = 1'b1;
    s_req.rready = 1'b1;
    step();
    m_rsp.rvalid = 1'b0;
    chk1("t2_s_rvalid", s_rsp.rvalid, 1'b1);
    step();
    step();
    chk1("t2_idle", idle, 1'b1);

`ifdef AXI4_BUF_OUTSTANDING_LIMIT_EN
    // outstanding cap of 2 reads
    idle_inputs();
    s_req.rready  = 1'b1;
    m_rsp.arready = 1'b1;
    bi = 0;
    for (int c = 0; c < 12 && bi < 3; c++) begin
      s_req.arvalid = 1'b1;
      s_req.arid    = 4'(bi + 5);
      s_req.araddr  = $urandom;
      step();
      if (g_ar_enq) bi++;
    end
    s_req.arvalid = 1'b0;
    repeat (3) step();
    chk1("t5_arvalid_held", m_req.arvalid, 1'b0);
    m_rsp.rvalid = 1'b1;
    m_rsp.rlast  = 1'b1;
    m_rsp.rid    = 4'd5;
    step();
    m_rsp.rvalid = 1'b0;
    chk1("t5_third_ar", m_req.arvalid, 1'b1);
    step();
    m_rsp.rvalid = 1'b1;
    repeat (2) step();
    m_rsp.rvalid = 1'b0;
    repeat (4) step();
    chk1("t5_idle", idle, 1'b1);
`endif

    // 8-beat W burst into a 4-deep FIFO
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      wd[i] = $urandom;
      ws[i] = 4'($urandom);
    end
    bi = 0;
    for (int c = 0; c < 40 && bi < 8; c++) begin
      s_req.wvalid = 1'b1;
      s_req.wdata  = wd[bi];
      s_req.wstrb  = ws[bi];
      s_req.wlast  = (bi == 7);
      if (c == 5) chk1("t3_wready_full", s_rsp.wready, 1'b0);
      if (c == 6) m_rsp.wready = 1'b1;
      step();
      if (g_w_enq) bi++;
    end
    chk("t3_beats_taken", 256'(bi), 256'(8));
    s_req.wvalid = 1'b0;
    repeat (8) step();

    // full W FIFO with simultaneous dequeue
    idle_inputs();
    repeat (4) begin
      s_req.wvalid = 1'b1;
      s_req.wdata  = $urandom;
      s_req.wstrb  = 4'($urandom);
      s_req.wlast  = 1'($urandom);
      step();
    end
    m_rsp.wready = 1'b1;
    chk1("t4_full_rdy", s_rsp.wready, 1'b0);
    step();
    s_req.wvalid = 1'b0;
    m_rsp.wready = 1'b0;
    chk1("t4_next_rdy", s_rsp.wready, 1'b1);
    step();
    m_rsp.wready = 1'b1;
    repeat (4) step();

    // random traffic on every channel
    for (int c = 0; c < 300; c++) begin
      rand_drive();
      step();
    end
    idle_inputs();
    s_req.bready  = 1'b1;
    s_req.rready  = 1'b1;
    m_rsp.awready = 1'b1;
    m_rsp.wready  = 1'b1;
    m_rsp.arready = 1'b1;
    repeat (8) step();

    // reset mid-burst with R FIFO holding beats
    idle_inputs();
    repeat (3) begin
      m_rsp.rvalid = 1'b1;
      m_rsp.rid    = 4'($urandom);
      m_rsp.rdata  = $urandom;
      m_rsp.rlast  = 1'b0;
      step();
    end
    m_rsp.rvalid = 1'b0;
    step();
    chk1("t6_pre_rvalid", s_rsp.rvalid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk1("t6_rvalid_async", s_rsp.rvalid, 1'b0);
    chk1("t6_rready_async", m_req.rready, 1'b0);
    chk1("t6_idle_async", idle, 1'b1);
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk1("t6_rready_pre", m_req.rready, 1'b0);
    @(posedge clk);
    #1;
    live = 1'b1;
    s_req.rready = 1'b1;
    s_req.bready = 1'b1;
    repeat (5) step();
    chk1("t6_idle_end", idle, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
